// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS subset core with req/ack instruction and data ports.
// Define MIPS_MC_BNE_EN to decode bne; otherwise opcode 000101 retires as a no-op.
module mips_multicycle_core #(
  parameter int          DADDR_W  = 7,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  input  logic               dmem_ack,
  input  logic [31:0]        dmem_rdata,
  output logic               rf_wen,
  output logic [4:0]         rf_waddr,
  output logic [31:0]        rf_wdata,
  output logic               retire
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  state_t state;
  logic [31:0] pc, ir, a, b, imm, alu_out, mdr, alu_r;
  logic [31:0] rf [32];
  logic [5:0] op, fn;
  logic is_r, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr, r_ok, take;
  assign op     = ir[31:26];
  assign fn     = ir[5:0];
  assign is_r   = op == 6'h00;
  assign is_lw  = op == 6'h23;
  assign is_sw  = op == 6'h2B;
  assign is_beq = op == 6'h04;
  assign is_j   = op == 6'h02;
  assign is_jal = op == 6'h03;
`ifdef MIPS_MC_BNE_EN
  assign is_bne = op == 6'h05;
`else
  assign is_bne = 1'b0;
`endif
  assign is_jr  = is_r && fn == 6'h08;
  assign r_ok   = is_r && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
  assign take   = (is_beq && a == b) || (is_bne && a != b);
  always_comb
    alu_r = fn == 6'h20 ? a + b :
            fn == 6'h22 ? a - b :
            fn == 6'h24 ? a & b :
            fn == 6'h25 ? a | b :
            {31'd0, $signed(a) < $signed(b)};
  // Outputs are gated by rst so an ack seen during reset never completes a handshake
  assign imem_req   = !rst && state == FETCH;
  assign imem_addr  = pc;
  assign dmem_req   = !rst && state == MEM;
  assign dmem_we    = dmem_req && is_sw;
  assign dmem_addr  = alu_out[DADDR_W+1:2];
  assign dmem_wdata = b;
  assign rf_wen     = !rst && (state == WB || (state == EXEC && is_jal));
  assign rf_waddr   = !rf_wen ? 5'd0 : state == EXEC ? 5'd31 : is_lw ? ir[20:16] : ir[15:11];
  assign rf_wdata   = !rf_wen ? 32'd0 : state == EXEC ? pc : is_lw ? mdr : alu_out;
  assign retire     = !rst && (state == WB ||
                               (state == EXEC && !is_lw && !is_sw && !r_ok) ||
                               (state == MEM && is_sw && dmem_ack));
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      imm     <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (rf_wen && rf_waddr != 5'd0) rf[rf_waddr] <= rf_wdata;
      case (state)
        FETCH: if (imem_ack) begin
          ir    <= imem_rdata;
          pc    <= pc + 32'd4;
          state <= DECODE;
        end
        DECODE: begin
          a     <= rf[ir[25:21]];
          b     <= rf[ir[20:16]];
          imm   <= {{16{ir[15]}}, ir[15:0]};
          state <= EXEC;
        end
        EXEC: begin
          alu_out <= is_r ? alu_r : a + imm;
          pc      <= take ? pc + (imm << 2) :
                     (is_j || is_jal) ? {pc[31:28], ir[25:0], 2'b00} :
                     is_jr ? a : pc;
          state   <= (is_lw || is_sw) ? MEM : r_ok ? WB : FETCH;
        end
        MEM: if (dmem_ack) begin
          mdr   <= dmem_rdata;
          state <= is_sw ? FETCH : WB;
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: directed program with ROM/SRAM models, wait-state and reset checks.
module tb_mips_multicycle_core;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic [31:0] imem_addr, imem_rdata, dmem_wdata, dmem_rdata, rf_wdata;
  logic [6:0]  dmem_addr;
  logic        rf_wen, retire;
  logic [4:0]  rf_waddr;
  logic [31:0] rom [128];
  logic [31:0] dram [128];
  int          iwait, iw_cnt;
  logic        dmem_hold;
  logic [6:0]  last_daddr;
  logic        last_dwe;
  logic [31:0] last_dwdata;
  int          checks = 0, errors = 0;

  mips_multicycle_core #(.DADDR_W(7), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .retire(retire)
  );

  always #5 clk = ~clk;

  assign imem_ack   = imem_req && (iw_cnt >= iwait);
  assign imem_rdata = rom[imem_addr[8:2]];
  assign dmem_ack   = dmem_req && !dmem_hold;
  assign dmem_rdata = dram[dmem_addr];

  always @(posedge clk) begin
    iw_cnt <= (rst || !imem_req || imem_ack) ? 0 : iw_cnt + 1;
    if (dmem_req && dmem_ack) begin
      last_daddr  <= dmem_addr;
      last_dwe    <= dmem_we;
      last_dwdata <= dmem_wdata;
      if (dmem_we) dram[dmem_addr] <= dmem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic run(input string tag, input int n0, input int exp_n);
    int n = n0;
    while (!retire && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, n, exp_n);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      rom[i]  = 32'h0;
      dram[i] = 32'h0;
    end
    rom[0]  = 32'h8C010004;
    rom[1]  = 32'h00211020;
    rom[2]  = 32'hAC020008;
    rom[3]  = 32'h00420020;
    rom[4]  = 32'h1000FFFE;
    rom[8]  = 32'h0C000040;
    rom[12] = 32'h14400001;
    rom[13] = 32'h8C010004;
    rom[14] = 32'h8C010004;
    rom[64] = 32'h00001820;
    rom[65] = 32'h0800000C;
    dram[1] = 32'h5;
    iwait = 0;
    iw_cnt = 0;
    dmem_hold = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rf_wen", rf_wen, 0);
    check("rst_retire", retire, 0);
    check("rst_dmem_req", dmem_req, 0);
    rst = 1'b0;
    #1;
    check("first_imem_req", imem_req, 1);
    check("first_imem_addr", imem_addr, 32'h0);
    run("lw_lat", 1, 5);
    check("lw_wen", rf_wen, 1);
    check("lw_waddr", rf_waddr, 1);
    check("lw_wdata", rf_wdata, 32'h5);
    nxt();
    check("lw_daddr", last_daddr, 1);
    check("lw_dwe", last_dwe, 0);
    check("fetch_4", imem_addr, 32'h4);
    run("add_lat", 1, 4);
    check("add_waddr", rf_waddr, 2);
    check("add_wdata", rf_wdata, 32'hA);
    iwait = 3;
    nxt();
    for (int k = 0; k < 3; k++) begin
      check("sw_wait_addr", imem_addr, 32'h8);
      check("sw_wait_ack", imem_ack, 0);
      @(negedge clk);
    end
    check("sw_ack_addr", imem_addr, 32'h8);
    run("sw_lat", 4, 7);
    check("sw_dreq", dmem_req, 1);
    check("sw_dwe", dmem_we, 1);
    check("sw_daddr", dmem_addr, 2);
    check("sw_dwdata", dmem_wdata, 32'hA);
    iwait = 0;
    nxt();
    check("sw_mem", dram[2], 32'hA);
    run("add0_lat", 1, 4);
    check("add0_wen", rf_wen, 1);
    check("add0_waddr", rf_waddr, 0);
    rom[3] = 32'h08000008;
    nxt();
    run("beq_lat", 1, 3);
    nxt();
    check("beq_target", imem_addr, 32'h0C);
    run("j_lat", 1, 3);
    nxt();
    check("j_target", imem_addr, 32'h20);
    run("jal_lat", 1, 3);
    check("jal_wen", rf_wen, 1);
    check("jal_waddr", rf_waddr, 31);
    check("jal_wdata", rf_wdata, 32'h24);
    nxt();
    check("jal_target", imem_addr, 32'h100);
    run("add3_lat", 1, 4);
    check("add3_waddr", rf_waddr, 3);
    check("r0_reads_zero", rf_wdata, 32'h0);
    nxt();
    run("j30_lat", 1, 3);
    nxt();
    check("j30_target", imem_addr, 32'h30);
    run("bne_lat", 1, 3);
    check("bne_wen", rf_wen, 0);
    nxt();
`ifdef MIPS_MC_BNE_EN
    check("bne_next", imem_addr, 32'h38);
`else
    check("bne_next", imem_addr, 32'h34);
`endif
    dmem_hold = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_dreq", dmem_req, 1);
    check("hold_dwe", dmem_we, 0);
    nxt();
    check("hold_dreq2", dmem_req, 1);
    check("hold_retire", retire, 0);
    rst = 1'b1;
    nxt();
    check("rst_mem_dreq", dmem_req, 0);
    check("rst_mem_pc", imem_addr, 32'h0);
    rom[0] = 32'h00422020;
    dmem_hold = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_mem_ireq", imem_req, 1);
    run("post_rst_lat", 1, 4);
    check("post_rst_waddr", rf_waddr, 4);
    check("regs_cleared", rf_wdata, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
